// File: rtl/light_counter.sv
//------------------------------------------------------------------------------
// Module      : light_counter
// Description : Per-phase countdown timer for the traffic-light controller.
//               A one-hot init pulse loads the phase duration; the count then
//               drops by one per enabled clock and saturates at zero. 'last'
//               flags the terminal count so the controller can advance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module light_counter #(
  parameter int pGREEN_INIT_VAL  = 14,
  parameter int pYELLOW_INIT_VAL = 2,
  parameter int pRED_INIT_VAL    = 17,
  parameter int pCNT_WIDTH       = $clog2(pRED_INIT_VAL + 1),
  parameter int pINIT_WIDTH      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [pINIT_WIDTH-1:0] init,
  output logic                   last,
  output logic [pCNT_WIDTH-1:0]  cnt_out
);

  // Load values sized to the counter width.
  localparam logic [pCNT_WIDTH-1:0] c_red    = pCNT_WIDTH'(pRED_INIT_VAL);
  localparam logic [pCNT_WIDTH-1:0] c_yellow = pCNT_WIDTH'(pYELLOW_INIT_VAL);
  localparam logic [pCNT_WIDTH-1:0] c_green  = pCNT_WIDTH'(pGREEN_INIT_VAL);
  localparam logic [pCNT_WIDTH-1:0] c_one    = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] c_zero   = '0;

  logic [pCNT_WIDTH-1:0] r_cnt;
  logic [pCNT_WIDTH-1:0] w_cnt_next;
  logic                  w_at_zero;

  assign w_at_zero = (r_cnt == c_zero);

  // Next count: loads take priority RED > YELLOW > GREEN and ignore en;
  // otherwise decrement while enabled, saturating at zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (init[2]) begin
      w_cnt_next = c_red;
    end else if (init[1]) begin
      w_cnt_next = c_yellow;
    end else if (init[0]) begin
      w_cnt_next = c_green;
    end else if (en && !w_at_zero) begin
      w_cnt_next = r_cnt - c_one;
    end
  end

  // Count register; asynchronous reset clears it and drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= c_zero;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt_out = r_cnt;
  assign last    = w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_light_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_light_counter
// Description : Self-checking bench for light_counter (vector table plus
//               hand-written reset sequences, scoreboard queue of expectations).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_light_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] init;
  logic       last;
  logic [4:0] cnt_out;

  int n_vec;
  int n_err;

  typedef struct {
    logic [2:0] init;
    logic       en;
    logic [4:0] exp_cnt;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  light_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .init    (init),
    .last    (last),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [4:0] e_cnt, input logic e_last);
    n_vec++;
    if (cnt_out !== e_cnt || last !== e_last) begin
      n_err++;
      $display("FAIL %s: cnt_out=%0d last=%0b, expected cnt_out=%0d last=%0b",
               name, cnt_out, last, e_cnt, e_last);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, and compare
  // once the rising edge has produced the result.
  task automatic step(input string name, input logic [2:0] i_init, input logic i_en,
                      input logic [4:0] e_cnt);
    vec_t v;
    v.init     = i_init;
    v.en       = i_en;
    v.exp_cnt  = e_cnt;
    v.exp_last = (e_cnt == 5'd0);
    exp_q.push_back(v);
    init = i_init;
    en   = i_en;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, expected cnt_out=%0d", name, e_cnt);
    end else begin
      v = exp_q.pop_front();
      check(name, v.exp_cnt, v.exp_last);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [2:0] i_init, input logic i_en, input int e_cnt);
    vec_t v;
    v.init     = i_init;
    v.en       = i_en;
    v.exp_cnt  = 5'(e_cnt);
    v.exp_last = (e_cnt == 0);
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    init  = 3'b000;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset", 5'd0, 1'b1);
    rst_n = 1'b1;
    step("reset_hold", 3'b000, 1'b0, 5'd0);
    step("idle_sat", 3'b000, 1'b1, 5'd0);

    // RED: load, 17 decrements to zero, then saturation.
    vecs.push_back(mk(3'b100, 1'b0, 17));
    for (int i = 16; i >= 0; i--) vecs.push_back(mk(3'b000, 1'b1, i));
    vecs.push_back(mk(3'b000, 1'b1, 0));
    vecs.push_back(mk(3'b000, 1'b1, 0));
    // YELLOW: 2,1,0.
    vecs.push_back(mk(3'b010, 1'b1, 2));
    vecs.push_back(mk(3'b000, 1'b1, 1));
    vecs.push_back(mk(3'b000, 1'b1, 0));
    // GREEN: 14 decrements to zero.
    vecs.push_back(mk(3'b001, 1'b1, 14));
    for (int i = 13; i >= 0; i--) vecs.push_back(mk(3'b000, 1'b1, i));
    // Reload mid-count at 9 with YELLOW.
    vecs.push_back(mk(3'b001, 1'b1, 14));
    for (int i = 13; i >= 9; i--) vecs.push_back(mk(3'b000, 1'b1, i));
    vecs.push_back(mk(3'b010, 1'b1, 2));
    // Priority and held reload.
    vecs.push_back(mk(3'b111, 1'b1, 17));
    vecs.push_back(mk(3'b011, 1'b1, 2));
    vecs.push_back(mk(3'b101, 1'b1, 17));
    vecs.push_back(mk(3'b100, 1'b1, 17));
    vecs.push_back(mk(3'b000, 1'b1, 16));
    // Enable gating: load with en=0, count to 10, freeze, resume.
    vecs.push_back(mk(3'b001, 1'b0, 14));
    for (int i = 13; i >= 10; i--) vecs.push_back(mk(3'b000, 1'b1, i));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b000, 1'b0, 10));
    vecs.push_back(mk(3'b000, 1'b1, 9));

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].init, vecs[i].en, vecs[i].exp_cnt);
    end

    // Async reset mid-count: continue from 9 down to 5, then reset between edges.
    for (int i = 8; i >= 5; i--) step("pre_rst", 3'b000, 1'b1, 5'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 5'd0, 1'b1);
    // A load request while reset is held must not take effect.
    init = 3'b100;
    en   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_blocks_load", 5'd0, 1'b1);
    @(negedge clk);
    init  = 3'b000;
    en    = 1'b0;
    rst_n = 1'b1;
    step("post_rst_hold", 3'b000, 1'b0, 5'd0);
    step("post_rst_load", 3'b001, 1'b0, 5'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
